regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding a 32-entry register file write port.
// Optional saturating conflict counter is enabled by defining WB_ARB_CONFLICT_CNT_EN.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               softReset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*5-1:0]  req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [31:0]        wr_enable,
    output logic [DW-1:0]      wr_data,
    output logic [4:0]         wr_addr
`ifdef WB_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]        conflict_cnt
`endif
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    logic [4:0]    win_addr;
    logic [DW-1:0] win_data;

    // Search upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        win       = '0;
        idx       = '0;
        found     = 1'b0;
        if (reset_n && !softReset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = PW'((int'(ptr) + k) % NREQ);
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        if (found) begin
            req_ready[win] = 1'b1;
        end
    end

    assign win_addr = req_addr[int'(win)*5 +: 5];
    assign win_data = req_data[int'(win)*DW +: DW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            wr_enable <= '0;
            wr_data   <= '0;
            wr_addr   <= '0;
        end else if (softReset) begin
            ptr       <= '0;
            wr_enable <= '0;
        end else if (found) begin
            ptr       <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            wr_data   <= win_data;
            wr_addr   <= win_addr;
            // Index 31 is the hardwired zero register: accepted but never enabled.
            wr_enable <= (win_addr == 5'd31) ? 32'd0 : (32'd1 << win_addr);
        end else begin
            wr_enable <= '0;
        end
    end

`ifdef WB_ARB_CONFLICT_CNT_EN
    logic multi;

    // More than one bit set is detected by clearing the lowest set bit.
    assign multi = |(req_valid & (req_valid - 1'b1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (multi && !softReset && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=4, DW=64).
// Conflict-counter checks are compiled only when WB_ARB_CONFLICT_CNT_EN is defined.
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         reset_n;
    logic         softReset;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  wr_enable;
    logic [63:0]  wr_data;
    logic [4:0]   wr_addr;
`ifdef WB_ARB_CONFLICT_CNT_EN
    logic [15:0]  conflict_cnt;
`endif

    int checks;
    int failures;
    int expConflict;

    regfile_wb_arbiter #(.NREQ(4), .DW(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .softReset (softReset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_enable (wr_enable),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr)
`ifdef WB_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic setReq(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic flush();
        @(negedge clk);
        req_valid = 4'b0000;
        softReset = 1'b1;
        @(negedge clk);
        softReset = 1'b0;
    endtask

    task automatic test_conflict(input string name);
`ifdef WB_ARB_CONFLICT_CNT_EN
        checks++;
        if (conflict_cnt !== 16'(expConflict)) begin
            failures++;
            $display("[TB] FAIL %s conflict_cnt actual=%0d expected=%0d", name, conflict_cnt, expConflict);
        end
`else
        if (name.len() < 0) $display("[TB] %s", name);
`endif
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        softReset = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_valid = 4'b1111;
        #12;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ready actual=%b expected=%b", req_ready, 4'b0000);
        end
        checks++;
        if (wr_enable !== 32'h0 || wr_data !== 64'h0 || wr_addr !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs actual=%h/%h/%0d expected=0/0/0", wr_enable, wr_data, wr_addr);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        reset_n   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wr_enable !== 32'h0 || wr_data !== 64'h0 || req_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL idle_cycle%0d actual=%h/%h/%b expected=0/0/0", c, wr_enable, wr_data, req_ready);
            end
        end
        expConflict = 0;
        test_conflict("idle");
    endtask

    task automatic test_single_write();
        @(negedge clk);
        setReq(0, 1'b1, 5'd5, 64'h1F);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_ready actual=%b expected=%b", req_ready, 4'b0001);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        checks++;
        if (wr_enable !== 32'h20 || wr_data !== 64'h1F || wr_addr !== 5'd5) begin
            failures++;
            $display("[TB] FAIL single_write actual=%h/%h/%0d expected=20/1f/5", wr_enable, wr_data, wr_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_enable !== 32'h0 || wr_data !== 64'h1F) begin
            failures++;
            $display("[TB] FAIL single_after actual=%h/%h expected=0/1f", wr_enable, wr_data);
        end
    endtask

    task automatic test_contention();
        int g;
        flush();
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 5'(i + 1), 64'hA0 + 64'(i));
        for (int c = 0; c < 5; c++) begin
            g = c % 4;
            #1;
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                failures++;
                $display("[TB] FAIL contention_grant%0d actual=%b expected=%b", c, req_ready, 4'(1 << g));
            end
            @(posedge clk);
            #1;
            checks++;
            if (wr_enable !== (32'h1 << (g + 1)) || wr_data !== 64'hA0 + 64'(g)) begin
                failures++;
                $display("[TB] FAIL contention_write%0d actual=%h/%h expected=%h/%h", c, wr_enable, wr_data, 32'h1 << (g + 1), 64'hA0 + 64'(g));
            end
        end
        expConflict += 5;
        test_conflict("contention");
        req_valid = 4'b0000;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        setReq(2, 1'b1, 5'd31, 64'hDEAD);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL zero_ready actual=%b expected=%b", req_ready, 4'b0100);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_enable !== 32'h0 || wr_addr !== 5'd31 || wr_data !== 64'hDEAD) begin
            failures++;
            $display("[TB] FAIL zero_write actual=%h/%0d/%h expected=0/31/dead", wr_enable, wr_addr, wr_data);
        end
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 5'(10 + i), 64'h100 + 64'(i));
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL zero_ptr actual=%b expected=%b", req_ready, 4'b1000);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        expConflict += 1;
        checks++;
        if (wr_enable !== 32'h2000 || wr_addr !== 5'd13) begin
            failures++;
            $display("[TB] FAIL zero_next actual=%h/%0d expected=2000/13", wr_enable, wr_addr);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        setReq(1, 1'b1, 5'd7, 64'h77);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 5'(20 + i), 64'h200 + 64'(i));
        softReset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL flush_ready actual=%b expected=%b", req_ready, 4'b0000);
        end
        @(posedge clk);
        #1;
        softReset = 1'b0;
        checks++;
        if (wr_enable !== 32'h0 || wr_addr !== 5'd7 || wr_data !== 64'h77) begin
            failures++;
            $display("[TB] FAIL flush_regs actual=%h/%0d/%h expected=0/7/77", wr_enable, wr_addr, wr_data);
        end
        test_conflict("flush");
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL flush_ptr actual=%b expected=%b", req_ready, 4'b0001);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        expConflict += 1;
        checks++;
        if (wr_enable !== 32'h0010_0000 || wr_addr !== 5'd20) begin
            failures++;
            $display("[TB] FAIL flush_resume actual=%h/%0d expected=100000/20", wr_enable, wr_addr);
        end
        test_conflict("flush_resume");
    endtask

    task automatic test_back_to_back();
        flush();
        setReq(0, 1'b1, 5'd9, 64'hAAAA);
        setReq(1, 1'b1, 5'd9, 64'hBBBB);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL b2b_grant0 actual=%b expected=%b", req_ready, 4'b0001);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        checks++;
        if (wr_enable !== 32'h200 || wr_data !== 64'hAAAA) begin
            failures++;
            $display("[TB] FAIL b2b_write0 actual=%h/%h expected=200/aaaa", wr_enable, wr_data);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL b2b_grant1 actual=%b expected=%b", req_ready, 4'b0010);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        expConflict += 1;
        checks++;
        if (wr_enable !== 32'h200 || wr_data !== 64'hBBBB) begin
            failures++;
            $display("[TB] FAIL b2b_write1 actual=%h/%h expected=200/bbbb", wr_enable, wr_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_enable !== 32'h0 || wr_data !== 64'hBBBB || wr_addr !== 5'd9) begin
            failures++;
            $display("[TB] FAIL b2b_hold actual=%h/%h/%0d expected=0/bbbb/9", wr_enable, wr_data, wr_addr);
        end
        test_conflict("b2b");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        setReq(0, 1'b1, 5'd3, 64'h33);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        checks++;
        if (wr_enable !== 32'h8) begin
            failures++;
            $display("[TB] FAIL async_pre actual=%h expected=%h", wr_enable, 32'h8);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_enable !== 32'h0 || wr_data !== 64'h0 || wr_addr !== 5'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_clear actual=%h/%h/%0d/%b expected=0/0/0/0", wr_enable, wr_data, wr_addr, req_ready);
        end
        expConflict = 0;
        test_conflict("async_clear");
        @(negedge clk);
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 5'(i + 1), 64'h300 + 64'(i));
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL async_resume_grant actual=%b expected=%b", req_ready, 4'b0001);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        expConflict += 1;
        checks++;
        if (wr_enable !== 32'h2 || wr_data !== 64'h300) begin
            failures++;
            $display("[TB] FAIL async_resume_write actual=%h/%h expected=2/300", wr_enable, wr_data);
        end
        test_conflict("async_resume");
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        expConflict = 0;
        test_reset();
        test_single_write();
        test_contention();
        test_zero_reg();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
